// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 INCR-burst memory slave backed by a 2**MEM_AW x 32-bit word array.
// One outstanding burst per direction; read and write channels run independently.
// Optional build macro AXI_SLAVE_THROTTLE_EN: an LFSR paces W ready and new R valid.
module axi_slave_mem #(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                SLAVE_CLK,
  input  logic                SLAVE_RST,
  input  logic [ID_WIDTH-1:0] SLAVE_WR_ADDR_ID,
  input  logic [31:0]         SLAVE_WR_ADDR,
  input  logic [7:0]          SLAVE_WR_ADDR_LEN,
  input  logic                SLAVE_WR_ADDR_VALID,
  output logic                SLAVE_WR_ADDR_READY,
  input  logic [31:0]         SLAVE_WR_DATA,
  input  logic [3:0]          SLAVE_WR_STRB,
  input  logic                SLAVE_WR_DATA_LAST,
  input  logic                SLAVE_WR_DATA_VALID,
  output logic                SLAVE_WR_DATA_READY,
  output logic [ID_WIDTH-1:0] SLAVE_WR_BACK_ID,
  output logic [1:0]          SLAVE_WR_BACK_RESP,
  output logic                SLAVE_WR_BACK_VALID,
  input  logic                SLAVE_WR_BACK_READY,
  input  logic [ID_WIDTH-1:0] SLAVE_RD_ADDR_ID,
  input  logic [31:0]         SLAVE_RD_ADDR,
  input  logic [7:0]          SLAVE_RD_ADDR_LEN,
  input  logic                SLAVE_RD_ADDR_VALID,
  output logic                SLAVE_RD_ADDR_READY,
  output logic [ID_WIDTH-1:0] SLAVE_RD_BACK_ID,
  output logic [31:0]         SLAVE_RD_DATA,
  output logic [1:0]          SLAVE_RD_DATA_RESP,
  output logic                SLAVE_RD_DATA_LAST,
  output logic                SLAVE_RD_DATA_VALID,
  input  logic                SLAVE_RD_DATA_READY
);

  localparam int unsigned DEPTH   = 2**MEM_AW;
  localparam logic [33:0] WIN_TOP = 34'(BASE_ADDR) + (34'd4 << MEM_AW) - 34'd1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // Burst is rejected if misaligned, below the window, or its last word lies above the window.
  function automatic logic f_dec_err(input logic [31:0] a, input logic [7:0] len);
    logic [33:0] last_byte;
    last_byte = {2'b00, a} + {24'd0, len, 2'b00};
    return ({2'b00, a} < 34'(BASE_ADDR)) || (a[1:0] != 2'b00) || (last_byte > WIN_TOP);
  endfunction

  function automatic logic [MEM_AW-1:0] f_word(input logic [31:0] a);
    return MEM_AW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] r_mem [DEPTH];

  w_state_t            r_w_state;
  logic                r_aw_ready, r_w_ready, r_b_valid;
  logic [ID_WIDTH-1:0] r_w_id, r_b_id;
  logic [1:0]          r_b_resp;
  logic [MEM_AW-1:0]   r_w_addr;
  logic [7:0]          r_w_len, r_w_beat;
  logic                r_w_err, r_w_slverr;

  r_state_t            r_rd_state;
  logic                r_ar_ready, r_r_valid, r_r_last;
  logic [ID_WIDTH-1:0] r_r_id;
  logic [31:0]         r_r_data;
  logic [1:0]          r_r_resp;
  logic [MEM_AW-1:0]   r_rd_addr;
  logic [7:0]          r_rd_len, r_rd_beat;
  logic                r_rd_err;

  logic              w_allow;
  logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_mem_we;
  logic              w_aw_err, w_ar_err;
  logic [MEM_AW-1:0] w_aw_word, w_ar_word;

`ifdef AXI_SLAVE_THROTTLE_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  // Registered ready/valid follow the LFSR value they will coincide with.
  assign w_allow = (w_lfsr_nxt[1:0] != 2'b00);

  // Free-running throttle LFSR.
  always_ff @(posedge SLAVE_CLK or posedge SLAVE_RST) begin
    if (SLAVE_RST) r_lfsr <= 16'hACE1;
    else           r_lfsr <= w_lfsr_nxt;
  end
`else
  assign w_allow = 1'b1;
`endif

  assign w_aw_hs   = r_aw_ready && SLAVE_WR_ADDR_VALID;
  assign w_w_hs    = r_w_ready  && SLAVE_WR_DATA_VALID;
  assign w_b_hs    = r_b_valid  && SLAVE_WR_BACK_READY;
  assign w_ar_hs   = r_ar_ready && SLAVE_RD_ADDR_VALID;
  assign w_r_hs    = r_r_valid  && SLAVE_RD_DATA_READY;
  assign w_mem_we  = w_w_hs && !r_w_err;
  assign w_aw_err  = f_dec_err(SLAVE_WR_ADDR, SLAVE_WR_ADDR_LEN);
  assign w_ar_err  = f_dec_err(SLAVE_RD_ADDR, SLAVE_RD_ADDR_LEN);
  assign w_aw_word = f_word(SLAVE_WR_ADDR);
  assign w_ar_word = f_word(SLAVE_RD_ADDR);

  // Byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge SLAVE_CLK) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (SLAVE_WR_STRB[i]) r_mem[r_w_addr][8*i +: 8] <= SLAVE_WR_DATA[8*i +: 8];
      end
    end
  end

  // Write FSM: accept AW, consume exactly LEN+1 W beats, then hold B until accepted.
  always_ff @(posedge SLAVE_CLK or posedge SLAVE_RST) begin
    if (SLAVE_RST) begin
      r_w_state  <= W_IDLE;
      r_aw_ready <= 1'b0;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_id     <= '0;
      r_b_resp   <= RESP_OKAY;
      r_w_id     <= '0;
      r_w_addr   <= '0;
      r_w_len    <= '0;
      r_w_beat   <= '0;
      r_w_err    <= 1'b0;
      r_w_slverr <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_ready <= 1'b0;
            r_w_id     <= SLAVE_WR_ADDR_ID;
            r_w_addr   <= w_aw_word;
            r_w_len    <= SLAVE_WR_ADDR_LEN;
            r_w_err    <= w_aw_err;
            r_w_beat   <= '0;
            r_w_slverr <= 1'b0;
            r_w_ready  <= w_allow;
            r_w_state  <= W_DATA;
          end else begin
            r_aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_w_addr <= r_w_addr + MEM_AW'(1);
            r_w_beat <= r_w_beat + 8'd1;
            if (r_w_beat == r_w_len) begin
              r_w_ready <= 1'b0;
              r_b_valid <= 1'b1;
              r_b_id    <= r_w_id;
              if (r_w_err)                                r_b_resp <= RESP_DECERR;
              else if (r_w_slverr || !SLAVE_WR_DATA_LAST) r_b_resp <= RESP_SLVERR;
              else                                        r_b_resp <= RESP_OKAY;
              r_w_state <= W_RESP;
            end else begin
              if (SLAVE_WR_DATA_LAST) r_w_slverr <= 1'b1;
              r_w_ready <= w_allow;
            end
          end else begin
            r_w_ready <= w_allow;
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_b_valid  <= 1'b0;
            r_aw_ready <= 1'b1;
            r_w_state  <= W_IDLE;
          end
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: each load fetches the next word on the same edge as the R handshake.
  always_ff @(posedge SLAVE_CLK or posedge SLAVE_RST) begin
    if (SLAVE_RST) begin
      r_rd_state <= R_IDLE;
      r_ar_ready <= 1'b0;
      r_r_valid  <= 1'b0;
      r_r_last   <= 1'b0;
      r_r_id     <= '0;
      r_r_data   <= '0;
      r_r_resp   <= RESP_OKAY;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_beat  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_ar_ready <= 1'b0;
            r_r_id     <= SLAVE_RD_ADDR_ID;
            r_rd_len   <= SLAVE_RD_ADDR_LEN;
            r_rd_err   <= w_ar_err;
            r_rd_state <= R_DATA;
            if (w_allow) begin
              r_r_valid <= 1'b1;
              r_r_data  <= w_ar_err ? 32'h0 : r_mem[w_ar_word];
              r_r_resp  <= w_ar_err ? RESP_DECERR : RESP_OKAY;
              r_r_last  <= (SLAVE_RD_ADDR_LEN == 8'd0);
              r_rd_addr <= w_ar_word + MEM_AW'(1);
              r_rd_beat <= 8'd1;
            end else begin
              r_rd_addr <= w_ar_word;
              r_rd_beat <= 8'd0;
            end
          end else begin
            r_ar_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_r_hs && r_r_last) begin
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
            r_ar_ready <= 1'b1;
            r_rd_state <= R_IDLE;
          end else if ((!r_r_valid || w_r_hs) && w_allow) begin
            r_r_valid <= 1'b1;
            r_r_data  <= r_rd_err ? 32'h0 : r_mem[r_rd_addr];
            r_r_resp  <= r_rd_err ? RESP_DECERR : RESP_OKAY;
            r_r_last  <= (r_rd_beat == r_rd_len);
            r_rd_addr <= r_rd_addr + MEM_AW'(1);
            r_rd_beat <= r_rd_beat + 8'd1;
          end else if (w_r_hs) begin
            r_r_valid <= 1'b0;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign SLAVE_WR_ADDR_READY = r_aw_ready;
  assign SLAVE_WR_DATA_READY = r_w_ready;
  assign SLAVE_WR_BACK_ID    = r_b_id;
  assign SLAVE_WR_BACK_RESP  = r_b_resp;
  assign SLAVE_WR_BACK_VALID = r_b_valid;
  assign SLAVE_RD_ADDR_READY = r_ar_ready;
  assign SLAVE_RD_BACK_ID    = r_r_id;
  assign SLAVE_RD_DATA       = r_r_data;
  assign SLAVE_RD_DATA_RESP  = r_r_resp;
  assign SLAVE_RD_DATA_LAST  = r_r_last;
  assign SLAVE_RD_DATA_VALID = r_r_valid;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed bench for axi_slave_mem (default build, BASE_ADDR=0, MEM_AW=10).
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  aw_id;   logic [31:0] aw_addr; logic [7:0] aw_len; logic aw_valid; logic aw_ready;
  logic [31:0] w_data;  logic [3:0]  w_strb;  logic w_last; logic w_valid; logic w_ready;
  logic [1:0]  b_id;    logic [1:0]  b_resp;  logic b_valid; logic b_ready;
  logic [1:0]  ar_id;   logic [31:0] ar_addr; logic [7:0] ar_len; logic ar_valid; logic ar_ready;
  logic [1:0]  r_id;    logic [31:0] r_data;  logic [1:0] r_resp; logic r_last; logic r_valid;
  logic        r_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [1:0]  rd_id   [16];
  int          rd_n;
  bit          rd_to;

  always #5 clk = ~clk;

  axi_slave_mem #(.ID_WIDTH(2), .MEM_AW(10), .BASE_ADDR(32'h0)) dut (
    .SLAVE_CLK(clk), .SLAVE_RST(rst),
    .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
    .SLAVE_WR_ADDR_VALID(aw_valid), .SLAVE_WR_ADDR_READY(aw_ready),
    .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
    .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(w_ready),
    .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp), .SLAVE_WR_BACK_VALID(b_valid),
    .SLAVE_WR_BACK_READY(b_ready),
    .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr), .SLAVE_RD_ADDR_LEN(ar_len),
    .SLAVE_RD_ADDR_VALID(ar_valid), .SLAVE_RD_ADDR_READY(ar_ready),
    .SLAVE_RD_BACK_ID(r_id), .SLAVE_RD_DATA(r_data), .SLAVE_RD_DATA_RESP(r_resp),
    .SLAVE_RD_DATA_LAST(r_last), .SLAVE_RD_DATA_VALID(r_valid), .SLAVE_RD_DATA_READY(r_ready)
  );

  // AW handshake followed by LEN+1 W beats of d0, d0+1, ...; LAST taken from last_mask.
  task automatic drv_aw_w(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] d0, input logic [3:0] strb, input logic [15:0] last_mask,
                          output int beats, output bit to);
    int n;
    beats = 0; to = 1'b0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_valid = 1'b1;
    n = 0;
    while (!aw_ready && n < 50) begin @(negedge clk); n++; end
    if (!aw_ready) begin to = 1'b1; aw_valid = 1'b0; return; end
    @(negedge clk);
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_data = d0 + 32'(i); w_strb = strb; w_last = last_mask[i]; w_valid = 1'b1;
      n = 0;
      while (!w_ready && n < 50) begin @(negedge clk); n++; end
      if (!w_ready) begin to = 1'b1; w_valid = 1'b0; return; end
      @(negedge clk);
      beats++;
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  // Accept one B response.
  task automatic drv_b(output logic [1:0] id, output logic [1:0] resp, output bit to);
    int n;
    id = 2'bxx; resp = 2'bxx; to = 1'b0;
    b_ready = 1'b1;
    n = 0;
    while (!b_valid && n < 50) begin @(negedge clk); n++; end
    if (!b_valid) begin to = 1'b1; b_ready = 1'b0; return; end
    id = b_id; resp = b_resp;
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  // Full-rate read burst; beats collected into rd_* arrays.
  task automatic drv_read(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    rd_n = 0; rd_to = 1'b0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_valid = 1'b1; r_ready = 1'b1;
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    if (!ar_ready) begin rd_to = 1'b1; ar_valid = 1'b0; return; end
    @(negedge clk);
    ar_valid = 1'b0;
    n = 0;
    while (rd_n <= int'(len) && rd_n < 16 && n < 300) begin
      if (r_valid) begin
        rd_data[rd_n] = r_data; rd_resp[rd_n] = r_resp; rd_last[rd_n] = r_last; rd_id[rd_n] = r_id;
        rd_n++;
      end
      @(negedge clk);
      n++;
    end
    if (rd_n <= int'(len)) rd_to = 1'b1;
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_last, r_id, r_resp, r_data} !== 47'd0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs aw_rdy=%b ar_rdy=%b b_v=%b r_v=%b r_data=%h expected all 0",
                         aw_ready, ar_ready, b_valid, r_valid, r_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({aw_ready, ar_ready} !== 2'b00) begin
      errors++; $display("FAIL ready_at_release: got %b expected 00", {aw_ready, ar_ready});
    end
    @(negedge clk);
    checks++;
    if ({aw_ready, ar_ready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_release: got %b expected 11", {aw_ready, ar_ready});
    end
  endtask

  task automatic test_basic();
    int beats; bit to; logic [1:0] id, resp;
    drv_aw_w(2'b01, 32'h0, 8'd3, 32'h10, 4'hF, 16'h0008, beats, to);
    checks++;
    if (to || beats != 4) begin errors++; $display("FAIL basic_w_beats: got %0d (to=%b) expected 4", beats, to); end
    drv_b(id, resp, to);
    checks++;
    if (to || id !== 2'b01 || resp !== 2'b00) begin
      errors++; $display("FAIL basic_b: got id=%b resp=%b to=%b expected id=01 resp=00", id, resp, to);
    end
    drv_read(2'b10, 32'h0, 8'd3);
    checks++;
    if (rd_to || rd_n != 4) begin errors++; $display("FAIL basic_r_beats: got %0d expected 4", rd_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 32'h10 + 32'(i) || rd_resp[i] !== 2'b00 || rd_id[i] !== 2'b10 || rd_last[i] !== (i == 3)) begin
        errors++; $display("FAIL basic_r_beat%0d: got data=%h resp=%b id=%b last=%b expected data=%h resp=00 id=10 last=%b",
                           i, rd_data[i], rd_resp[i], rd_id[i], rd_last[i], 32'h10 + 32'(i), (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    int beats; bit to; logic [1:0] id, resp;
    drv_aw_w(2'b00, 32'h20, 8'd0, 32'hFFFF_FFFF, 4'hF, 16'h0001, beats, to);
    drv_b(id, resp, to);
    drv_aw_w(2'b11, 32'h20, 8'd0, 32'hAABB_CCDD, 4'b0101, 16'h0001, beats, to);
    drv_b(id, resp, to);
    checks++;
    if (to || id !== 2'b11 || resp !== 2'b00) begin
      errors++; $display("FAIL strobe_b: got id=%b resp=%b expected id=11 resp=00", id, resp);
    end
    drv_read(2'b00, 32'h20, 8'd0);
    checks++;
    if (rd_to || rd_data[0] !== 32'hFFBB_FFDD || rd_last[0] !== 1'b1) begin
      errors++; $display("FAIL strobe_data: got %h last=%b expected ffbbffdd last=1", rd_data[0], rd_last[0]);
    end
  endtask

  task automatic test_decerr();
    int beats; bit to; logic [1:0] id, resp;
    drv_aw_w(2'b00, 32'hFFC, 8'd0, 32'h5A5A_5A5A, 4'hF, 16'h0001, beats, to);
    drv_b(id, resp, to);
    drv_aw_w(2'b10, 32'hFFC, 8'd1, 32'hDEAD_0000, 4'hF, 16'h0002, beats, to);
    checks++;
    if (to || beats != 2) begin errors++; $display("FAIL decerr_w_beats: got %0d expected 2", beats); end
    drv_b(id, resp, to);
    checks++;
    if (to || id !== 2'b10 || resp !== 2'b11) begin
      errors++; $display("FAIL decerr_b: got id=%b resp=%b expected id=10 resp=11", id, resp);
    end
    drv_read(2'b00, 32'hFFC, 8'd0);
    checks++;
    if (rd_to || rd_data[0] !== 32'h5A5A_5A5A || rd_resp[0] !== 2'b00) begin
      errors++; $display("FAIL decerr_mem_kept: got %h resp=%b expected 5a5a5a5a resp=00", rd_data[0], rd_resp[0]);
    end
    drv_read(2'b01, 32'hFFC, 8'd1);
    checks++;
    if (rd_to || rd_n != 2 || rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0 || rd_resp[0] !== 2'b11 ||
        rd_resp[1] !== 2'b11 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
      errors++; $display("FAIL decerr_r: got n=%0d d0=%h d1=%h r0=%b r1=%b l0=%b l1=%b expected n=2 data 0 resp 11 last 0,1",
                         rd_n, rd_data[0], rd_data[1], rd_resp[0], rd_resp[1], rd_last[0], rd_last[1]);
    end
    drv_aw_w(2'b00, 32'hFF8, 8'd1, 32'h7777_0000, 4'hF, 16'h0002, beats, to);
    drv_b(id, resp, to);
    checks++;
    if (to || resp !== 2'b00) begin errors++; $display("FAIL top_fit_b: got resp=%b expected 00", resp); end
    drv_read(2'b00, 32'hFF8, 8'd1);
    checks++;
    if (rd_to || rd_data[0] !== 32'h7777_0000 || rd_data[1] !== 32'h7777_0001 || rd_resp[1] !== 2'b00) begin
      errors++; $display("FAIL top_fit_r: got %h %h resp=%b expected 77770000 77770001 resp=00", rd_data[0], rd_data[1], rd_resp[1]);
    end
    drv_read(2'b00, 32'h102, 8'd0);
    checks++;
    if (rd_to || rd_resp[0] !== 2'b11 || rd_data[0] !== 32'h0) begin
      errors++; $display("FAIL misaligned_r: got resp=%b data=%h expected resp=11 data=0", rd_resp[0], rd_data[0]);
    end
    drv_read(2'b00, 32'h1000, 8'd0);
    checks++;
    if (rd_to || rd_resp[0] !== 2'b11) begin
      errors++; $display("FAIL outside_r: got resp=%b expected 11", rd_resp[0]);
    end
  endtask

  task automatic test_stall();
    int beats; bit to; logic [1:0] id, resp;
    int got, n;
    bit prev_stall;
    logic [36:0] prev_pl;
    drv_aw_w(2'b11, 32'h60, 8'd3, 32'hC0, 4'hF, 16'h0008, beats, to);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (b_valid !== 1'b1 || b_id !== 2'b11 || b_resp !== 2'b00 || aw_ready !== 1'b0) begin
        errors++; $display("FAIL b_stall_c%0d: got valid=%b id=%b resp=%b aw_ready=%b expected 1 11 00 0",
                           c, b_valid, b_id, b_resp, aw_ready);
      end
      @(negedge clk);
    end
    drv_b(id, resp, to);
    checks++;
    if (to || id !== 2'b11 || resp !== 2'b00) begin
      errors++; $display("FAIL b_stall_resp: got id=%b resp=%b expected 11 00", id, resp);
    end
    checks++;
    if (b_valid !== 1'b0) begin errors++; $display("FAIL b_once: got b_valid=%b expected 0", b_valid); end
    ar_id = 2'b01; ar_addr = 32'h60; ar_len = 8'd3; ar_valid = 1'b1; r_ready = 1'b0;
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    ar_valid = 1'b0;
    got = 0; prev_stall = 1'b0; prev_pl = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      r_ready = c[0];
      if (prev_stall) begin
        checks++;
        if ({r_valid, r_data, r_last, r_id, r_resp} !== {1'b1, prev_pl}) begin
          errors++; $display("FAIL r_stall_stable: got valid=%b pl=%h expected valid=1 pl=%h",
                             r_valid, {r_data, r_last, r_id, r_resp}, prev_pl);
        end
      end
      checks++;
      if (ar_ready !== 1'b0) begin errors++; $display("FAIL r_stall_ar_ready: got %b expected 0", ar_ready); end
      if (r_valid && r_ready) begin
        checks++;
        if (r_data !== 32'hC0 + 32'(got) || r_last !== (got == 3) || r_id !== 2'b01) begin
          errors++; $display("FAIL r_stall_beat%0d: got data=%h last=%b id=%b expected data=%h last=%b id=01",
                             got, r_data, r_last, r_id, 32'hC0 + 32'(got), (got == 3));
        end
        got++;
      end
      prev_stall = r_valid && !r_ready;
      prev_pl = {r_data, r_last, r_id, r_resp};
      @(negedge clk);
    end
    r_ready = 1'b0;
    checks++;
    if (got != 4 || r_valid !== 1'b0 || ar_ready !== 1'b1) begin
      errors++; $display("FAIL r_stall_end: got beats=%0d r_valid=%b ar_ready=%b expected 4 0 1", got, r_valid, ar_ready);
    end
  endtask

  task automatic test_slverr_concurrent();
    int beats; bit to; logic [1:0] id, resp;
    fork
      begin
        drv_aw_w(2'b00, 32'h80, 8'd3, 32'h900, 4'hF, 16'h0002, beats, to);
        drv_b(id, resp, to);
      end
      drv_read(2'b10, 32'h0, 8'd3);
    join
    checks++;
    if (to || beats != 4 || resp !== 2'b10) begin
      errors++; $display("FAIL early_last: got beats=%0d resp=%b expected 4 resp=10", beats, resp);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_to || rd_data[i] !== 32'h10 + 32'(i) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
        errors++; $display("FAIL concurrent_r%0d: got %h resp=%b last=%b expected %h resp=00 last=%b",
                           i, rd_data[i], rd_resp[i], rd_last[i], 32'h10 + 32'(i), (i == 3));
      end
    end
    drv_read(2'b00, 32'h80, 8'd3);
    checks++;
    if (rd_to || rd_data[0] !== 32'h900 || rd_data[3] !== 32'h903) begin
      errors++; $display("FAIL early_last_mem: got %h..%h expected 00000900..00000903", rd_data[0], rd_data[3]);
    end
    drv_aw_w(2'b01, 32'hA0, 8'd1, 32'h1, 4'hF, 16'h0000, beats, to);
    checks++;
    if (w_ready !== 1'b0) begin errors++; $display("FAIL extra_beat_ready: got %b expected 0", w_ready); end
    drv_b(id, resp, to);
    checks++;
    if (to || resp !== 2'b10 || id !== 2'b01) begin
      errors++; $display("FAIL missing_last: got id=%b resp=%b expected 01 10", id, resp);
    end
  endtask

  task automatic test_reset_mid();
    int beats; bit to; logic [1:0] id, resp;
    int n;
    drv_aw_w(2'b00, 32'h100, 8'd7, 32'h1000, 4'hF, 16'h0080, beats, to);
    drv_b(id, resp, to);
    ar_id = 2'b11; ar_addr = 32'h100; ar_len = 8'd7; ar_valid = 1'b1; r_ready = 1'b1;
    n = 0;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    ar_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (r_valid !== 1'b0 || r_last !== 1'b0) begin
      errors++; $display("FAIL async_reset_rvalid: got valid=%b last=%b expected 0 0", r_valid, r_last);
    end
    @(negedge clk);
    rst = 1'b0;
    r_ready = 1'b0;
    #1;
    checks++;
    if (ar_ready !== 1'b0 || r_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release: got ar_ready=%b r_valid=%b expected 0 0", ar_ready, r_valid);
    end
    @(negedge clk);
    checks++;
    if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release_next: got ar_ready=%b r_valid=%b expected 1 0", ar_ready, r_valid);
    end
    drv_read(2'b01, 32'h100, 8'd7);
    checks++;
    if (rd_to || rd_n != 8) begin errors++; $display("FAIL fresh_r_beats: got %0d expected 8", rd_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== 32'h1000 + 32'(i) || rd_last[i] !== (i == 7) || rd_id[i] !== 2'b01) begin
        errors++; $display("FAIL fresh_r%0d: got %h last=%b id=%b expected %h last=%b id=01",
                           i, rd_data[i], rd_last[i], rd_id[i], 32'h1000 + 32'(i), (i == 7));
      end
    end
  endtask

  initial begin
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0; r_ready = 1'b0;
    test_reset();
    test_basic();
    test_strobe();
    test_decerr();
    test_stall();
    test_slverr_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no completion after 20000 cycles expected finish");
    $fatal(1);
  end

endmodule
